// File: rtl/param_mem_hs.sv
// Parametrised single-port synchronous RAM with valid/ready requests, byte enables,
// an RD_LAT-cycle read pipe and a zeroing INIT sweep after reset. Optional parity: PARITY_EN.
module param_mem_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef PARITY_EN
  input  logic                inj_perr,
  output logic [DATA_W/8-1:0] rsp_perr,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done
);

  // state   | meaning
  // ST_INIT | sweeping zeros into addr init_cnt, requests not accepted
  // ST_RUN  | normal operation, one request per cycle
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int                NB      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
  logic              ready_nxt;
  logic              init_we;

  logic              accept, in_range, wr_en, rd_acc;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] v_pipe;
  logic [DATA_W-1:0] d_pipe [RD_LAT];

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ready_nxt    = 1'b0;
    init_we      = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_cnt == LAST) begin
          state_nxt = ST_RUN;
          ready_nxt = 1'b1;
        end else begin
          init_cnt_nxt = init_cnt + 1'b1;
        end
      end
      ST_RUN:  ready_nxt = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      req_ready <= ready_nxt;
      init_done <= ready_nxt;
    end
  end

  assign accept   = req_valid & req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_V;
  assign wr_en    = accept & req_we & in_range;
  assign rd_acc   = accept & ~req_we;
  assign rd_word  = in_range ? mem[req_addr] : '0;

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Each stage only loads on a valid beat, so the output holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_acc;
      if (rd_acc) d_pipe[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign rsp_valid = v_pipe[RD_LAT-1];
  assign rsp_rdata = d_pipe[RD_LAT-1];

`ifdef PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_perr;
  logic [NB-1:0] p_pipe [RD_LAT];

  // Stored bit makes each byte-plus-parity even; inj_perr flips it to force a check failure.
  always_ff @(posedge clk) begin
    if (init_we) begin
      par[init_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) par[req_addr][b] <= (^req_wdata[8*b +: 8]) ^ inj_perr;
      end
    end
  end

  always_comb begin
    rd_perr = '0;
    if (in_range) begin
      for (int b = 0; b < NB; b++) rd_perr[b] = (^rd_word[8*b +: 8]) ^ par[req_addr][b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) p_pipe[i] <= '0;
    end else begin
      if (rd_acc) p_pipe[0] <= rd_perr;
      for (int i = 1; i < RD_LAT; i++) begin
        if (v_pipe[i-1]) p_pipe[i] <= p_pipe[i-1];
      end
    end
  end

  assign rsp_perr = p_pipe[RD_LAT-1];
`endif

endmodule

// File: tb/tb_param_mem_hs.sv
// Bench for param_mem_hs: a 16-word RD_LAT=2 instance and a 12-word RD_LAT=1 instance
// share one request bus and are checked against a word-array model every cycle.
module tb_param_mem_hs;
  localparam int NI = 2;

  typedef struct {
    int         due;
    logic [31:0] data;
    logic [3:0]  perr;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        inj_perr = 1'b0;
  logic [NI-1:0]       ready, vld, idone;
  logic [NI-1:0][31:0] rdata;
`ifdef PARITY_EN
  logic [NI-1:0][3:0]  perr;
`endif

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] m_mem [NI][16];
  logic [3:0]  m_bad [NI][16];
  int          m_cnt [NI];
  logic [31:0] m_last [NI];
  rsp_t        q0[$];
  rsp_t        q1[$];

  always #5 clk = ~clk;

  param_mem_hs #(.DATA_W(32), .DEPTH(16), .RD_LAT(2)) u_main (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef PARITY_EN
    .inj_perr(inj_perr), .rsp_perr(perr[0]),
`endif
    .rsp_valid(vld[0]), .rsp_rdata(rdata[0]), .init_done(idone[0])
  );

  param_mem_hs #(.DATA_W(32), .DEPTH(12), .RD_LAT(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef PARITY_EN
    .inj_perr(inj_perr), .rsp_perr(perr[1]),
`endif
    .rsp_valid(vld[1]), .rsp_rdata(rdata[1]), .init_done(idone[1])
  );

  function automatic int dep(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(int k);
    m_cnt[k]  = 0;
    m_last[k] = '0;
    for (int a = 0; a < 16; a++) begin
      m_mem[k][a] = '0;
      m_bad[k][a] = '0;
    end
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic compare(int k);
    rsp_t r;
    bit   due;
    due = 1'b0;
    if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin r = q0.pop_front(); due = 1'b1; end
    if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin r = q1.pop_front(); due = 1'b1; end
    check($sformatf("req_ready%0d", k), ready[k], m_cnt[k] >= dep(k));
    check($sformatf("init_done%0d", k), idone[k], m_cnt[k] >= dep(k));
    check($sformatf("rsp_valid%0d", k), vld[k], due);
    if (due) begin
      m_last[k] = r.data;
`ifdef PARITY_EN
      check($sformatf("rsp_perr%0d", k), perr[k], r.perr);
`endif
    end
    check($sformatf("rsp_rdata%0d", k), rdata[k], m_last[k]);
  endtask

  // One clock: decide acceptance from the model, apply it at the edge, check #1 later.
  task automatic step();
    bit   acc [NI];
    rsp_t r;
    bit   inr;
    for (int k = 0; k < NI; k++) acc[k] = (rst_n === 1'b1) && req_valid && (m_cnt[k] >= dep(k));
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        model_reset(k);
      end else begin
        inr = int'(req_addr) < dep(k);
        if (acc[k] && req_we && inr) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
              m_mem[k][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
              m_bad[k][req_addr][b] = inj_perr;
            end
          end
        end else if (acc[k] && !req_we) begin
          r.due  = cyc + lat(k) - 1;
          r.data = inr ? m_mem[k][req_addr] : '0;
          r.perr = inr ? m_bad[k][req_addr] : '0;
          if (k == 0) q0.push_back(r); else q1.push_back(r);
        end
        if (m_cnt[k] < dep(k)) m_cnt[k]++;
      end
    end
    #1;
    for (int k = 0; k < NI; k++) compare(k);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic op(bit we, int addr, logic [31:0] d, logic [3:0] be, bit inj);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = 4'(addr);
    req_wdata = d;
    req_be    = be;
    inj_perr  = inj;
    step();
    req_valid = 1'b0;
    inj_perr  = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      model_reset(k);
      check($sformatf("rst_valid%0d", k), vld[k], 1'b0);
      check($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      check($sformatf("rst_ready%0d", k), ready[k], 1'b0);
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) model_reset(k);
    idle(2);
    rst_n = 1'b1;

    // 1: held write during INIT must be ignored, then zeros everywhere
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    repeat (10) step();
    idle(6);
    op(0, 5, '0, '0, 0);
    op(0, 2, '0, '0, 0);
    idle(2);
    check("t1_rd2_zero", rdata[0], 32'h0);

    // 2 and 3: full write, then partial byte-enable merge
    op(1, 3, 32'hDEAD_BEEF, 4'hF, 0);
    op(0, 3, '0, '0, 0);
    idle(2);
    check("t2_data", rdata[0], 32'hDEAD_BEEF);
    op(1, 3, 32'h1122_3344, 4'b0101, 0);
    op(0, 3, '0, '0, 0);
    idle(2);
    check("t3_merge", rdata[0], 32'hDE22_BE44);
    op(1, 3, 32'h5555_5555, 4'h0, 0);
    op(0, 3, '0, '0, 0);
    idle(2);
    check("t3_be0_noop", rdata[0], 32'hDE22_BE44);

    // 4: fill then back-to-back reads; the 12-word instance drops 12..15
    for (int i = 0; i < 16; i++) op(1, i, 32'(i) * 32'h0101_0101, 4'hF, 0);
    for (int i = 0; i < 16; i++) op(0, i, '0, '0, 0);
    idle(3);
    check("t4_last", rdata[0], 32'h0F0F_0F0F);
    check("t4_oor", rdata[1], 32'h0);
    op(0, 11, '0, '0, 0);
    idle(2);
    check("t4_odd_top", rdata[1], 32'h0B0B_0B0B);

    // 5: reset with reads in flight
    op(0, 3, '0, '0, 0);
    op(0, 5, '0, '0, 0);
    async_reset();
    idle(16);
    op(0, 3, '0, '0, 0);
    idle(2);
    check("t5_rezeroed", rdata[0], 32'h0);

`ifdef PARITY_EN
    // 6: injected parity error, then clean rewrite
    op(1, 7, 32'hA5C3_0F81, 4'hF, 1);
    op(0, 7, '0, '0, 0);
    idle(1);
    check("t6_perr", perr[0], 4'hF);
    op(1, 7, 32'hA5C3_0F81, 4'hF, 0);
    op(0, 7, '0, '0, 0);
    idle(1);
    check("t6_clean", perr[0], 4'h0);
`endif

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      inj_perr  = ($urandom_range(0, 7) == 0);
      step();
    end
    inj_perr = 1'b0;
    idle(4);
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
